// File: rtl/imemrwpx_pkg.sv
// Shared constants and address helper for the imemrwpx write-side blocks.
package imemrwpx_pkg;

  localparam int unsigned NCH_DEF     = 4;
  localparam int unsigned CHBIT_DEF   = 2;
  localparam int unsigned ADDRBIT_DEF = 9;
  localparam int unsigned WIDTH_DEF   = 32;
  localparam int unsigned SEGBIT_DEF  = ADDRBIT_DEF - CHBIT_DEF;
  // Occupancy needs one extra bit so a completely full segment is representable.
  localparam int unsigned CNTBIT_DEF  = SEGBIT_DEF + 1;

  function automatic logic [31:0] seg_addr(input int unsigned ch, input int unsigned off,
                                           input int unsigned segbit);
    return (ch << segbit) | off;
  endfunction

endpackage

// File: rtl/imemrwpx_wrarb_if.sv
// Channel-side write handshake: per-channel request level, data, and one-hot grant.
interface imemrwpx_wrarb_if
  import imemrwpx_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic [NCH-1:0]       req;
  logic [NCH*WIDTH-1:0] chdi;
  logic [NCH-1:0]       gnt;

  modport master (output req, output chdi, input gnt);
  modport slave  (input req, input chdi, output gnt);

endinterface

// File: rtl/warb_rr.sv
// Round-robin picker: first eligible channel at or above the rotating pointer wins.
module warb_rr
  import imemrwpx_pkg::*;
#(
  parameter int unsigned NCH   = NCH_DEF,
  parameter int unsigned CHBIT = CHBIT_DEF
) (
  input  logic           wrclk,
  input  logic           wrst_,
  input  logic [NCH-1:0] i_elig,
  output logic [NCH-1:0] o_gnt
);

  logic [CHBIT-1:0] r_rrp;
  logic [CHBIT-1:0] w_rrp_d;
  logic [CHBIT-1:0] w_idx;
  logic             w_found;

  // NCH is a power of two, so the index wraps naturally in CHBIT bits.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_rrp_d = r_rrp;
    w_idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_idx = r_rrp + CHBIT'(i);
      if (!w_found && i_elig[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
        w_rrp_d      = w_idx + CHBIT'(1);
      end
    end
  end

  always_ff @(posedge wrclk or negedge wrst_) begin
    if (!wrst_) r_rrp <= '0;
    else        r_rrp <= w_rrp_d;
  end

endmodule

// File: rtl/imemrwpx_wrarb.sv
// Write-port arbiter and per-channel ring-buffer sequencer for the shared imemrwpx RAM.
module imemrwpx_wrarb
  import imemrwpx_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned CHBIT   = CHBIT_DEF,
  parameter int unsigned ADDRBIT = ADDRBIT_DEF,
  parameter int unsigned WIDTH   = WIDTH_DEF,
  parameter int unsigned SEGBIT  = ADDRBIT - CHBIT
) (
  input  logic                       wrclk,
  input  logic                       wrst_,
  imemrwpx_wrarb_if.slave            bus,
  input  logic [NCH-1:0]             i_rel,
  input  logic [NCH-1:0]             i_flush,
  input  logic                       i_unfclr,
  output logic [ADDRBIT-1:0]         o_wa,
  output logic                       o_we,
  output logic [WIDTH-1:0]           o_di,
  output logic [NCH-1:0]             o_full,
  output logic [NCH*(SEGBIT+1)-1:0]  o_cnt,
  output logic [NCH*SEGBIT-1:0]      o_wptr,
  output logic                       o_unf
);

  localparam int unsigned CNTBIT = SEGBIT + 1;
  localparam logic [CNTBIT-1:0] CntFull = CNTBIT'(1) << SEGBIT;

  logic [CNTBIT-1:0]  r_cnt    [NCH];
  logic [CNTBIT-1:0]  w_cnt_d  [NCH];
  logic [SEGBIT-1:0]  r_wptr   [NCH];
  logic [SEGBIT-1:0]  w_wptr_d [NCH];
  logic [NCH-1:0]     r_full, w_full_d;
  logic [NCH-1:0]     w_elig, w_gnt;
  logic [CHBIT-1:0]   w_gidx;
  logic               w_unf_set;
  logic               r_we, r_unf;
  logic [ADDRBIT-1:0] r_wa, w_wa;
  logic [WIDTH-1:0]   r_di, w_di;

  // Gating with wrst_ keeps gnt low while reset is held.
  assign w_elig = bus.req & ~r_full & ~i_flush & {NCH{wrst_}};

  warb_rr #(
    .NCH   (NCH),
    .CHBIT (CHBIT)
  ) u_rr (
    .wrclk  (wrclk),
    .wrst_  (wrst_),
    .i_elig (w_elig),
    .o_gnt  (w_gnt)
  );

  assign bus.gnt = w_gnt;

  always_comb begin
    w_gidx = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (w_gnt[k]) w_gidx = CHBIT'(k);
    end
  end

  assign w_wa = ADDRBIT'(seg_addr(32'(w_gidx), 32'(r_wptr[w_gidx]), SEGBIT));
  assign w_di = bus.chdi[32'(w_gidx)*WIDTH +: WIDTH];

  always_comb begin
    w_unf_set = 1'b0;
    w_full_d  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_cnt_d[k]  = r_cnt[k];
      w_wptr_d[k] = r_wptr[k];
      if (i_flush[k]) begin
        w_cnt_d[k]  = '0;
        w_wptr_d[k] = '0;
      end else begin
        if (w_gnt[k]) w_wptr_d[k] = r_wptr[k] + SEGBIT'(1);
        case ({w_gnt[k], i_rel[k]})
          2'b10:   w_cnt_d[k] = r_cnt[k] + CNTBIT'(1);
          2'b01: begin
            if (r_cnt[k] == '0) w_unf_set  = 1'b1;
            else                w_cnt_d[k] = r_cnt[k] - CNTBIT'(1);
          end
          default: ;
        endcase
      end
      w_full_d[k] = (w_cnt_d[k] == CntFull);
    end
  end

  always_ff @(posedge wrclk or negedge wrst_) begin
    if (!wrst_) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        r_cnt[k]  <= '0;
        r_wptr[k] <= '0;
      end
      r_full <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        r_cnt[k]  <= w_cnt_d[k];
        r_wptr[k] <= w_wptr_d[k];
      end
      r_full <= w_full_d;
    end
  end

  always_ff @(posedge wrclk or negedge wrst_) begin
    if (!wrst_) begin
      r_we  <= 1'b0;
      r_wa  <= '0;
      r_di  <= '0;
      r_unf <= 1'b0;
    end else begin
      r_we <= |w_gnt;
      if (|w_gnt) begin
        r_wa <= w_wa;
        r_di <= w_di;
      end
      if (w_unf_set)     r_unf <= 1'b1;
      else if (i_unfclr) r_unf <= 1'b0;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_out
    assign o_cnt[k*CNTBIT +: CNTBIT]  = r_cnt[k];
    assign o_wptr[k*SEGBIT +: SEGBIT] = r_wptr[k];
  end

  assign o_full = r_full;
  assign o_we   = r_we;
  assign o_wa   = r_wa;
  assign o_di   = r_di;
  assign o_unf  = r_unf;

endmodule

// File: doc/imemrwpx_wrarb.md
# imemrwpx_wrarb

Write-side arbiter and address sequencer for a shared dual-clock RAM (`imemrwpx`). It shares the single RAM write port among NCH requesting channels using round-robin arbitration. It carves the RAM into NCH equal ring-buffer segments, and maintains per-channel write pointers and occupancy counters. Reads drain each segment from the rdclk side and return space via per-channel release pulses, already synchronised into wrclk.

## Interface
Parameters:
- NCH, 4, number of channels; power of two.
- CHBIT, 2, log2(NCH).
- ADDRBIT, 9, RAM address width.
- WIDTH, 32, data width.
- SEGBIT, ADDRBIT-CHBIT, per-channel segment address width (segment depth 2^SEGBIT).

Ports:
- wrclk  in  1  write clock.
- wrst_  in  1  reset, asynchronous, active-low.
- req  in  NCH  per-channel write request; level.
- chdi  in  NCH*WIDTH  per-channel write data; channel i at [i*WIDTH +: WIDTH].
- gnt  out  NCH  one-hot grant; combinational; data accepted in the cycle gnt[i]=1.
- rel  in  NCH  per-channel release pulse; one entry freed per pulse.
- flush  in  NCH  per-channel segment clear.
- wa  out  ADDRBIT  RAM write address, {channel, wptr}; registered.
- we  out  1  RAM write enable; registered.
- di  out  WIDTH  RAM write data; registered.
- full  out  NCH  segment full; registered.
- cnt  out  NCH*(SEGBIT+1)  per-channel occupancy; registered.
- wptr  out  NCH*SEGBIT  per-channel next write offset; registered.
- unf  out  1  sticky: a release arrived on an empty channel.
- unfclr  in  1  clears unf.

## Operation
- Eligible vector: elig = req & ~full & ~flush.
- Round-robin selection:
  - Grant the first eligible channel searching upward from rrp, wrapping at NCH.
  - At most one gnt bit per cycle; gnt = 0 when elig = 0.
  - rrp resets to 0. On a grant to channel k, rrp <= (k+1) mod NCH. rrp holds when there is no grant.
- On a grant to k:
  - next cycle: we=1, wa={k, wptr[k]}, di=chdi[k].
  - wptr[k] <= wptr[k]+1 mod 2^SEGBIT; wrap is silent.
- With no grant: we=0. wa and di hold their last values.
- Occupancy cnt[k]:
  - grant only: +1.
  - rel only: -1.
  - grant and rel in the same cycle: unchanged.
- rel[k] while cnt[k]=0 (and no grant): cnt stays 0 and unf <= 1.
- full[k] = (cnt[k] == 2^SEGBIT); it is a registered copy of next-state cnt. A full channel is never granted. A rel in a cycle where the channel is full clears full the next cycle.
- flush[k]:
  - next cycle: cnt[k]=0, wptr[k]=0, full[k]=0.
  - blocks a grant to k that cycle; rel[k] is ignored that cycle.
  - other channels are unaffected.
- unf: set has priority over unfclr in the same cycle.
- Reset values: gnt=0 (no requests are eligible while in reset), we=0, wa=0, di=0, cnt=0, wptr=0, full=0, unf=0, rrp=0.
- Reset mid-operation:
  - all state is cleared asynchronously and any registered write in flight is dropped (we forced to 0).
  - The read side must be reset concurrently.

## Timing
- req to gnt: 0 cycles (combinational). gnt to we/wa/di: 1 wrclk.
- The wrapper registers again, so the RAM array is written 2 wrclk after gnt.
- gnt/rel to cnt and full: 1 cycle.
- Throughput: one write per cycle aggregate. A single requester holding req with no contention is granted every cycle until full.
- The read side must not issue rel for an entry until it has read it. rel must arrive at least 3 wrclk after the corresponding gnt, which covers the write-pipeline depth.

## Structure
- Shared package `imemrwpx_pkg`:
  - constants NCH_DEF and CHBIT_DEF.
  - function seg_addr(ch, off) returning {ch, off}.
  - occupancy width localparam SEGBIT+1.
- Sub-module `warb_rr`:
  - parameterised NCH round-robin picker: elig and rrp in, one-hot gnt out.
  - contains the next-rrp logic.
- Top level holds the pointer and counter arrays, the output registers and the unf flag. It does not instantiate the RAM; the integrating level connects wa/we/di to `imemrwpx`.

## Test plan
- Single channel: req[2] held with NCH=4, SEGBIT=7 → gnt[2] every cycle for 128 cycles. wa steps 0x100..0x17F. full[2]=1 after the 128th grant, then gnt=0.
- Contention: req=4'b1111 held from reset → gnt sequence 0,1,2,3,0,… Each wptr advances once per 4 cycles.
- Skip: req=4'b1010, rrp=0 → gnt 1,3,1,3.
- Same-cycle grant+rel on channel 0 with cnt=5 → cnt stays 5. rel on channel 1 with cnt=0 → unf=1, cnt=0. unfclr → unf=0.
- Full recovery: channel 3 full. rel[3] pulse → full[3]=0 next cycle, then gnt[3] → full[3]=1 again.
- Flush/reset: flush[0] while req[0]=1 and cnt=40 → no gnt[0] that cycle; next cycle cnt=0, wptr=0. wrst_ asserted mid-burst → we=0 immediately and all counters 0.
